// File: rtl/control_fsm.sv
// Multi-cycle control unit for the RV32 subset datapath (add, sub, xor, srl, addi, lw, sw, beq).
// Sequences fetch/decode/execute/memory/writeback and flags illegal opcodes and memory timeouts.
module control_fsm #(
  parameter int BEQ_EXEC_CYCLES = 3,
  parameter int MEM_TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        pcsrc,
  output logic [3:0]  estado,
  output logic        alusrc,
  output logic [3:0]  alucontrol,
  output logic        branch,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        pc_sel,
  output logic        regwrite,
  output logic        memtoreg,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        erro
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'b0000,
    S_DECODE = 4'b0001,
    S_EXEC_R = 4'b0010,
    S_WB_ALU = 4'b0011,
    S_EXEC_I = 4'b0101,
    S_EXEC_B = 4'b0110,
    S_MEM_RD = 4'b0111,
    S_WB_MEM = 4'b1000,
    S_MEM_WR = 4'b1001,
    S_BR_PC  = 4'b1010,
    S_ERROR  = 4'b1111
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_ADD, C_SUB, C_XOR, C_SRL, C_ADDI, C_LW, C_SW, C_BEQ
  } class_t;

  localparam logic [2:0] BEQ_LAST = 3'(BEQ_EXEC_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  class_t     class_q, dec_class, act_class;
  logic [7:0] wait_q, wait_d;
  logic [2:0] beq_q, beq_d;
  logic       in_mem_state;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    dec_class = C_NONE;
    case (opcode)
      7'b0110011: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000)      dec_class = C_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'b0100000) dec_class = C_SUB;
        else if (funct3 == 3'b100 && funct7 == 7'b0000000) dec_class = C_XOR;
        else if (funct3 == 3'b101 && funct7 == 7'b0000000) dec_class = C_SRL;
      end
      7'b0010011: if (funct3 == 3'b000) dec_class = C_ADDI;
      7'b0000011: if (funct3 == 3'b010) dec_class = C_LW;
      7'b0100011: if (funct3 == 3'b010) dec_class = C_SW;
      7'b1100011: if (funct3 == 3'b000) dec_class = C_BEQ;
      default:    dec_class = C_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      class_q <= C_NONE;
      wait_q  <= 8'd0;
      beq_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beq_q   <= beq_d;
      if (state_q == S_DECODE) class_q <= dec_class;
    end
  end

  // ALU controls track the instruction being decoded in DECODE, then the latched class.
  assign act_class = (state_q == S_DECODE) ? dec_class : class_q;
  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  // Memory handshake: mem_req stays high for the whole memory state; the access completes in
  // the cycle where mem_req=1 and mem_ready=1, and only one access is ever outstanding.
  always_comb begin
    state_d    = state_q;
    wait_d     = 8'd0;
    beq_d      = beq_q;
    alusrc     = 1'b0;
    alucontrol = 4'b0000;
    branch     = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    pc_sel     = 1'b0;
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    erro       = 1'b0;

    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (dec_class)
          C_ADD, C_SUB, C_XOR, C_SRL: state_d = S_EXEC_R;
          C_ADDI, C_LW, C_SW:         state_d = S_EXEC_I;
          C_BEQ:                      state_d = S_EXEC_B;
          default:                    state_d = S_ERROR;
        endcase
      end
      S_EXEC_R: state_d = S_WB_ALU;
      S_EXEC_I: begin
        if (class_q == C_LW)      state_d = S_MEM_RD;
        else if (class_q == C_SW) state_d = S_MEM_WR;
        else                      state_d = S_WB_ALU;
      end
      S_WB_ALU, S_WB_MEM, S_BR_PC: state_d = S_FETCH;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: if (mem_ready) state_d = S_FETCH;
      S_EXEC_B: begin
        if (beq_q == BEQ_LAST) begin
          state_d = S_BR_PC;
          beq_d   = 3'd0;
        end else begin
          beq_d = beq_q + 3'd1;
        end
      end
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase

    // A ready on the final allowed wait cycle still completes the access.
    if (in_mem_state && !mem_ready) begin
      if (wait_q == WAIT_LAST) state_d = S_ERROR;
      else                     wait_d  = wait_q + 8'd1;
    end

    if (rst_n) begin
      if (state_q != S_FETCH && state_q != S_ERROR) begin
        case (act_class)
          C_ADD, C_LW, C_SW: alucontrol = 4'b0010;
          C_SUB, C_BEQ:      alucontrol = 4'b0110;
          C_XOR:             alucontrol = 4'b0100;
          C_SRL:             alucontrol = 4'b0101;
          C_ADDI:            alucontrol = 4'b0011;
          default:           alucontrol = 4'b0000;
        endcase
        alusrc = (act_class == C_ADDI) || (act_class == C_LW) ||
                 (act_class == C_SW)   || (act_class == C_BEQ);
      end
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        S_WB_ALU: regwrite = 1'b1;
        S_WB_MEM: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        S_EXEC_B: begin
          branch     = 1'b1;
          alusrc     = 1'b1;
          alucontrol = 4'b0110;
        end
        S_BR_PC: begin
          pcwrite = pcsrc;
          pc_sel  = pcsrc;
        end
        S_ERROR: erro = 1'b1;
        default: ;
      endcase
    end
  end

  assign estado = state_q;

endmodule
